// File: rtl/sensor_spi_pkg.sv
// Shared definitions for the sensor SPI packet master.
// Contents: packet geometry, byte offsets, flag bit positions, the
// transmitter state type, the sampled-sensor struct and the packet builder.
// Optional feature macro: SPI_PKT_CHECKSUM_EN (byte 15 = XOR of bytes 0..14;
// when undefined, bytes 14 and 15 are both 8'h00).
package sensor_spi_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int PKT_BYTES = 16;
  localparam int PKT_BITS  = 128;

  // Byte offsets inside the packet (byte 0 goes on the wire first).
  localparam int HEADER    = 0;
  localparam int ROLL_MSB  = 1;
  localparam int ROLL_LSB  = 2;
  localparam int PITCH_MSB = 3;
  localparam int PITCH_LSB = 4;
  localparam int YAW_MSB   = 5;
  localparam int YAW_LSB   = 6;
  localparam int GX_MSB    = 7;
  localparam int GX_LSB    = 8;
  localparam int GY_MSB    = 9;
  localparam int GY_LSB    = 10;
  localparam int GZ_MSB    = 11;
  localparam int GZ_LSB    = 12;
  localparam int FLAGS     = 13;
  localparam int RSVD      = 14;
  localparam int CHKSUM    = 15;

  localparam int FLAG_EULER_BIT = 0;
  localparam int FLAG_GYRO_BIT  = 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} tx_state_t;

  typedef struct packed {
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic signed [15:0] yaw;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
    logic               euler_v;
    logic               gyro_v;
  } sensor_sample_t;

  // XOR of every byte before the checksum slot; byte 0 sits in the top bits.
  function automatic logic [7:0] pkt_xor(input logic [PKT_BITS-1:0] pkt);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < CHKSUM; i++) begin
      acc = acc ^ pkt[PKT_BITS-1-8*i -: 8];
    end
    return acc;
  endfunction

  // Lay the sample out as the 128-bit wire image, MSB = first bit sent.
  function automatic logic [PKT_BITS-1:0] build_packet(input sensor_sample_t s);
    logic [7:0]          b [PKT_BYTES];
    logic [PKT_BITS-1:0] v;
    b[HEADER]    = HEADER_BYTE;
    b[ROLL_MSB]  = s.roll[15:8];
    b[ROLL_LSB]  = s.roll[7:0];
    b[PITCH_MSB] = s.pitch[15:8];
    b[PITCH_LSB] = s.pitch[7:0];
    b[YAW_MSB]   = s.yaw[15:8];
    b[YAW_LSB]   = s.yaw[7:0];
    b[GX_MSB]    = s.gyro_x[15:8];
    b[GX_LSB]    = s.gyro_x[7:0];
    b[GY_MSB]    = s.gyro_y[15:8];
    b[GY_LSB]    = s.gyro_y[7:0];
    b[GZ_MSB]    = s.gyro_z[15:8];
    b[GZ_LSB]    = s.gyro_z[7:0];
    b[FLAGS]     = 8'h00;
    b[FLAGS][FLAG_EULER_BIT] = s.euler_v;
    b[FLAGS][FLAG_GYRO_BIT]  = s.gyro_v;
    b[RSVD]      = 8'h00;
    b[CHKSUM]    = 8'h00;
    v = '0;
    for (int i = 0; i < PKT_BYTES; i++) begin
      v[PKT_BITS-1-8*i -: 8] = b[i];
    end
`ifdef SPI_PKT_CHECKSUM_EN
    v[7:0] = pkt_xor(v);
`endif
    return v;
  endfunction

endpackage

// File: rtl/sensor_spi_packet_master_tick_gen.sv
// spi_sck_tick_gen: half-period strobe generator for the SPI clock.
// Ports: clk, rst_n (async active-low), en (counter held clear when low),
//        rise / fall (one-cycle strobes, alternating, rise first).
// The first strobe (a rise) fires on the first enabled cycle, then one
// strobe every SCK_HALF cycles.
module spi_sck_tick_gen #(
  parameter int unsigned SCK_HALF = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          tick_s;

  assign tick_s = en && (cnt_q == CW'(0));
  assign rise   = tick_s && !phase_q;
  assign fall   = tick_s && phase_q;

  // Next half-period count and rise/fall phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = CW'(0);
      phase_d = 1'b0;
    end else begin
      if (cnt_q == CW'(SCK_HALF - 1)) begin
        cnt_d = CW'(0);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (tick_s) begin
        phase_d = !phase_q;
      end else begin
        phase_d = phase_q;
      end
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CW'(0);
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sensor_spi_packet_master.sv
// sensor_spi_packet_master: SPI mode-0 master sending one 16-byte sensor
// packet per accepted sample, MSB first.
// Ports: clk, rst_n (async active-low); in_valid/in_ready handshake;
//        roll/pitch/yaw/gyro_x/gyro_y/gyro_z (signed 16-bit), euler_v, gyro_v;
//        cs_n, sck, sdo (registered SPI pins); busy, done (status).
// Optional feature macro: SPI_PKT_CHECKSUM_EN (see sensor_spi_pkg).
// Timing: cs_n low = CS_LEAD + 256*SCK_HALF + CS_TRAIL cycles. SHIFT covers
// 128 full SCK periods, so it ends one low half-period after the last fall.
module sensor_spi_packet_master
  import sensor_spi_pkg::*;
#(
  parameter int unsigned SCK_HALF = 15,
  parameter int unsigned CS_LEAD  = 60,
  parameter int unsigned CS_TRAIL = 30,
  parameter int unsigned CS_GAP   = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] pitch,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] gyro_x,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] gyro_z,
  input  logic               euler_v,
  input  logic               gyro_v,
  output logic               cs_n,
  output logic               sck,
  output logic               sdo,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = 16;

  tx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PKT_BITS-1:0]   shreg_q, shreg_d;
  logic [6:0]            bit_cnt_q, bit_cnt_d;
  logic                  fin_q, fin_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  in_ready_q, in_ready_d;
  sensor_sample_t        sample_s;
  logic [PKT_BITS-1:0]   pkt_s;
  logic                  sck_rise_s, sck_fall_s;

  assign sample_s.roll    = roll;
  assign sample_s.pitch   = pitch;
  assign sample_s.yaw     = yaw;
  assign sample_s.gyro_x  = gyro_x;
  assign sample_s.gyro_y  = gyro_y;
  assign sample_s.gyro_z  = gyro_z;
  assign sample_s.euler_v = euler_v;
  assign sample_s.gyro_v  = gyro_v;
  assign pkt_s            = build_packet(sample_s);

  // LEAD hands over one cycle early: the tick generator strobes a rise on
  // its first enabled cycle, so the registered sck rises CS_LEAD after cs_n.
  spi_sck_tick_gen #(.SCK_HALF(SCK_HALF)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == SHIFT),
    .rise (sck_rise_s),
    .fall (sck_fall_s)
  );

  // Next-state and next-output logic for the packet FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    fin_d      = fin_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    in_ready_d = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = LEAD;
          shreg_d    = pkt_s;
          sdo_d      = pkt_s[PKT_BITS-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
          cnt_d      = '0;
          bit_cnt_d  = 7'd0;
          fin_d      = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      LEAD: begin
        if (cnt_q == CNT_W'(CS_LEAD - 2)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (sck_rise_s) begin
          // The rise slot after the 128th fall closes the last period.
          if (fin_q) begin
            state_d = TRAIL;
            cnt_d   = '0;
          end else begin
            sck_d = 1'b1;
          end
        end else if (sck_fall_s) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 7'd127) begin
            fin_d = 1'b1;
          end else begin
            shreg_d   = {shreg_q[PKT_BITS-2:0], 1'b0};
            sdo_d     = shreg_q[PKT_BITS-2];
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else begin
          sck_d = sck_q;
        end
      end
      TRAIL: begin
        if (cnt_q == CNT_W'(CS_TRAIL - 1)) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          sdo_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        cs_n_d     = 1'b1;
        sck_d      = 1'b0;
        sdo_d      = 1'b0;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
        cnt_d      = '0;
      end
    endcase
  end

  // FSM state, counters, shift register and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= 7'd0;
      fin_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      fin_q      <= fin_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign sck      = sck_q;
  assign sdo      = sdo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;

endmodule
